// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the FSM encoding, the reset fetch address and the sequential PC step.
package ysyx_22050710_ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
  localparam int unsigned IFU_INST_STEP = 4;

endpackage

// File: rtl/ysyx_22050710_ifu_outbuf.sv
// Output register presenting a fetched instruction to ID.
// Load captures pc/inst and raises valid; clear drops valid only; otherwise holds.
module ysyx_22050710_ifu_outbuf #(
  parameter int unsigned PC_WD   = 32,
  parameter int unsigned INST_WD = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [PC_WD-1:0]   i_pc,
  input  logic [INST_WD-1:0] i_inst,
  output logic               o_valid,
  output logic [PC_WD-1:0]   o_pc,
  output logic [INST_WD-1:0] o_inst
);

  logic               valid_q, valid_d;
  logic [PC_WD-1:0]   pc_q, pc_d;
  logic [INST_WD-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (i_clear) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d = 1'b1;
      pc_d    = i_pc;
      inst_d  = i_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign o_valid = valid_q;
  assign o_pc    = pc_q;
  assign o_inst  = inst_q;

endmodule

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// hands each instruction to ID; a taken branch kills wrong-path work and refetches.
module ysyx_22050710_ifu
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter int unsigned      PC_WD    = 32,
  parameter int unsigned      INST_WD  = 32,
  parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(IFU_RESET_PC)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_br_valid,
  input  logic               i_br_taken,
  input  logic [PC_WD-1:0]   i_br_target,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [PC_WD-1:0]   o_imem_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INST_WD-1:0] i_imem_rdata,
  output logic               o_if_valid,
  input  logic               i_id_ready,
  output logic [PC_WD-1:0]   o_if_pc,
  output logic [INST_WD-1:0] o_if_inst
);

  localparam logic [PC_WD-1:0] PC_STEP = PC_WD'(IFU_INST_STEP);

  ifu_state_e       state_q, state_d;
  logic [PC_WD-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic             redirect;
  logic             buf_load, buf_clear, buf_valid;

  assign redirect = i_br_valid & i_br_taken;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) pc_d = i_br_target;
      end
      ST_REQ: begin
        if (redirect) pc_d = i_br_target;
        if (i_imem_req_ready) begin
          // The accepted request targets the old pc; it is wrong-path if redirected now.
          kill_d  = redirect;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_imem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = ST_REQ;
          if (redirect) begin
            pc_d = i_br_target;
          end else if (!kill_q) begin
            buf_load = 1'b1;
            pc_d     = pc_q + PC_STEP;
            state_d  = ST_HOLD;
          end
        end else if (redirect) begin
          pc_d   = i_br_target;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect || i_id_ready) begin
          buf_clear = 1'b1;
          state_d   = ST_REQ;
        end
        if (redirect) pc_d = i_br_target;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  ysyx_22050710_ifu_outbuf #(
    .PC_WD  (PC_WD),
    .INST_WD(INST_WD)
  ) u_outbuf (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (buf_load),
    .i_clear(buf_clear),
    .i_pc   (pc_q),
    .i_inst (i_imem_rdata),
    .o_valid(buf_valid),
    .o_pc   (o_if_pc),
    .o_inst (o_if_inst)
  );

  assign o_imem_req_valid = (state_q == ST_REQ);
  assign o_imem_addr      = pc_q;
  // The buffer's valid tracks HOLD exactly; the state decode keeps the handshake timing explicit.
  assign o_if_valid       = (state_q == ST_HOLD) & buf_valid;

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Bench for the fetch unit: directed scenarios plus randomized traffic, checked
// against a transaction-level model of fetch address, in-flight request and held instruction.
module tb_ysyx_22050710_ifu;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_br_valid, i_br_taken;
  logic [31:0] i_br_target;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic        i_id_ready;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_inst;

  always #5 i_clk = ~i_clk;

  ysyx_22050710_ifu #(
    .PC_WD   (32),
    .INST_WD (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_br_valid      (i_br_valid),
    .i_br_taken      (i_br_taken),
    .i_br_target     (i_br_target),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr     (o_imem_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rdata    (i_imem_rdata),
    .o_if_valid      (o_if_valid),
    .i_id_ready      (i_id_ready),
    .o_if_pc         (o_if_pc),
    .o_if_inst       (o_if_inst)
  );

  int unsigned n_pass, n_total;
  int          cyc;

  // reference model: where the next fetch must go, what is in flight, what is held
  bit          m_idle, m_busy, m_stale, m_hold;
  logic [31:0] m_fetch_pc, m_inflight, m_hold_pc, m_hold_inst;

  // memory model
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;

  logic [31:0] req_log[$];
  logic [31:0] pres_log[$];
  int          pres_cyc[$];
  bit          prev_ifv;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_check();
    bit exp_req;
    exp_req = !m_idle && !m_busy && !m_hold;
    check("req_valid", {31'd0, o_imem_req_valid}, {31'd0, exp_req});
    check("if_valid", {31'd0, o_if_valid}, {31'd0, m_hold});
    if (exp_req) check("imem_addr", o_imem_addr, m_fetch_pc);
    if (m_hold) begin
      check("if_pc", o_if_pc, m_hold_pc);
      check("if_inst", o_if_inst, m_hold_inst);
    end
    if (o_if_valid && !prev_ifv) begin
      pres_log.push_back(o_if_pc);
      pres_cyc.push_back(cyc);
    end
    prev_ifv = o_if_valid;
  endtask

  // One clock: drive inputs at the falling edge, advance models, check at next falling edge.
  task automatic tick(input bit bv, input bit bt, input logic [31:0] tgt,
                      input bit rdy, input bit idr);
    bit          redir, rsp, hs;
    logic [31:0] rdata;
    redir = bv && bt;
    rsp   = mem_pend && (mem_cnt == 0);
    rdata = rsp ? inst_of(mem_addr) : $urandom;
    hs    = o_imem_req_valid && rdy;
    if (rsp) assert (!o_imem_req_valid && !o_if_valid)
      else $error("imem response while not waiting");
    i_br_valid       = bv;
    i_br_taken       = bt;
    i_br_target      = tgt;
    i_imem_req_ready = rdy;
    i_imem_rsp_valid = rsp;
    i_imem_rdata     = rdata;
    i_id_ready       = idr;

    if (m_idle) begin
      m_idle = 0;
      if (redir) m_fetch_pc = tgt;
    end else if (m_hold) begin
      if (redir || idr) m_hold = 0;
      if (redir) m_fetch_pc = tgt;
    end else if (m_busy) begin
      if (rsp) begin
        m_busy = 0;
        if (redir) m_fetch_pc = tgt;
        else if (!m_stale) begin
          m_hold      = 1;
          m_hold_pc   = m_inflight;
          m_hold_inst = rdata;
          m_fetch_pc  = m_inflight + 32'd4;
        end
        m_stale = 0;
      end else if (redir) begin
        m_fetch_pc = tgt;
        m_stale    = 1;
      end
    end else begin
      if (rdy) begin
        m_busy     = 1;
        m_stale    = redir;
        m_inflight = m_fetch_pc;
      end
      if (redir) m_fetch_pc = tgt;
    end

    if (rsp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (hs) begin
      mem_pend = 1;
      mem_addr = o_imem_addr;
      mem_cnt  = lat - 1;
      req_log.push_back(o_imem_addr);
    end

    @(negedge i_clk);
    cyc++;
    model_check();
  endtask

  task automatic do_reset();
    i_rst_n          = 1'b0;
    i_br_valid       = 1'b0;
    i_br_taken       = 1'b0;
    i_br_target      = '0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rdata     = '0;
    i_id_ready       = 1'b0;
    m_idle = 1; m_busy = 0; m_stale = 0; m_hold = 0;
    m_fetch_pc = 32'h8000_0000;
    mem_pend = 0; mem_cnt = 0; lat = 1;
    req_log.delete(); pres_log.delete(); pres_cyc.delete();
    prev_ifv = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
    check("rst_imem_addr", o_imem_addr, 32'h8000_0000);
    check("rst_if_pc", o_if_pc, 32'd0);
    check("rst_if_inst", o_if_inst, 32'd0);
    i_rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 20 && !o_if_valid; i++) tick(0, 0, '0, 1, 0);
    check("wait_hold", {31'd0, o_if_valid}, 32'd1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;

    // sequential fetch, zero-wait memory
    do_reset();
    repeat (10) tick(0, 0, '0, 1, 1);
    check("t1_req0", at(req_log, 0), 32'h8000_0000);
    check("t1_req1", at(req_log, 1), 32'h8000_0004);
    check("t1_req2", at(req_log, 2), 32'h8000_0008);
    check("t1_pres0", at(pres_log, 0), 32'h8000_0000);
    check("t1_pres1", at(pres_log, 1), 32'h8000_0004);
    check("t1_pres2", at(pres_log, 2), 32'h8000_0008);
    check("t1_gap01", pres_cyc.size() >= 3 ? 32'(pres_cyc[1] - pres_cyc[0]) : 32'd0, 32'd3);
    check("t1_gap12", pres_cyc.size() >= 3 ? 32'(pres_cyc[2] - pres_cyc[1]) : 32'd0, 32'd3);

    // ID stalls for 5 cycles
    wait_hold();
    check("t2_pc", o_if_pc, 32'h8000_000C);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, '0, 1, 0);
      check("t2_stall_valid", {31'd0, o_if_valid}, 32'd1);
      check("t2_stall_pc", o_if_pc, 32'h8000_000C);
      check("t2_stall_inst", o_if_inst, inst_of(32'h8000_000C));
      check("t2_stall_noreq", {31'd0, o_imem_req_valid}, 32'd0);
    end
    tick(0, 0, '0, 1, 1);
    check("t2_req_after", {31'd0, o_imem_req_valid}, 32'd1);
    check("t2_addr_after", o_imem_addr, 32'h8000_0010);

    // redirect coincident with a request handshake
    do_reset();
    repeat (4) tick(0, 0, '0, 1, 1);
    check("t3_addr", o_imem_addr, 32'h8000_0004);
    tick(1, 1, 32'h8000_1000, 1, 1);
    tick(0, 0, '0, 0, 1);
    check("t3_hs_addr", at(req_log, 1), 32'h8000_0004);
    check("t3_req", {31'd0, o_imem_req_valid}, 32'd1);
    check("t3_target", o_imem_addr, 32'h8000_1000);
    check("t3_npres", pres_log.size(), 32'd1);

    // redirect while waiting; response arrives 3 cycles later
    lat = 4;
    tick(0, 0, '0, 1, 1);
    tick(1, 1, 32'h8000_2000, 0, 1);
    repeat (3) tick(0, 0, '0, 0, 1);
    lat = 1;
    check("t4_req", {31'd0, o_imem_req_valid}, 32'd1);
    check("t4_target", o_imem_addr, 32'h8000_2000);
    check("t4_npres", pres_log.size(), 32'd1);

    // redirect in HOLD together with id_ready
    wait_hold();
    check("t5_pc", o_if_pc, 32'h8000_2000);
    tick(1, 1, 32'h8000_3000, 0, 1);
    check("t5_drop", {31'd0, o_if_valid}, 32'd0);
    check("t5_req", {31'd0, o_imem_req_valid}, 32'd1);
    check("t5_target", o_imem_addr, 32'h8000_3000);

    // PC wrap, then reset during WAIT
    tick(1, 1, 32'hFFFF_FFFC, 0, 1);
    check("t6_unaccepted_redir", o_imem_addr, 32'hFFFF_FFFC);
    wait_hold();
    check("t6_pc_top", o_if_pc, 32'hFFFF_FFFC);
    tick(0, 0, '0, 0, 1);
    check("t6_wrap", o_imem_addr, 32'h0000_0000);
    lat = 8;
    tick(0, 0, '0, 1, 1);
    tick(0, 0, '0, 0, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, o_imem_req_valid}, 32'd0);
    check("t6_async_ifv", {31'd0, o_if_valid}, 32'd0);
    check("t6_async_addr", o_imem_addr, 32'h8000_0000);
    check("t6_async_pc", o_if_pc, 32'd0);
    check("t6_async_inst", o_if_inst, 32'd0);
    @(negedge i_clk);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          bv, bt;
      logic [31:0] tgt;
      lat = int'($urandom_range(1, 4));
      bv  = ($urandom % 6) == 0;
      bt  = ($urandom % 2) == 0;
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : $urandom;
      tick(bv, bt, tgt, ($urandom % 3) != 0, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
